// File: rtl/uart_rx_game_state_pkg.sv
// Shared types and constants for the game-state UART receiver.
package uart_rx_game_state_pkg;

    // Receiver FSM states; also exported on the debug port of the bus.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Command bytes shared with the transmitter side.
    localparam logic [7:0] GAME_START = 8'h01;
    localparam logic [7:0] GAME_STOP  = 8'h00;

    // 100 MHz / 115200 baud.
    localparam int UART_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_game_state_if.sv
// Output bus of the game-state receiver towards the game control logic.
//
// Handshake: valid-only, no backpressure. rx_valid is a one-cycle pulse that
// marks the cycle rx_data was updated; rx_data then holds until the next good
// byte, so the consumer may take it any time within one frame time.
// frame_err and state_changed are one-cycle pulses, game_running is a level.
interface uart_rx_game_state_if;
    import uart_rx_game_state_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       game_running;
    logic       state_changed;
    rx_state_e  dbg_state;

    modport master (
        output rx_data, rx_valid, frame_err, game_running, state_changed, dbg_state
    );

    modport slave (
        input rx_data, rx_valid, frame_err, game_running, state_changed, dbg_state
    );

endinterface

// File: rtl/uart_rx_game_state_core.sv
// 8N1 LSB-first UART receiver: input synchroniser, bit FSM and shift register.
module uart_rx_game_state_core
    import uart_rx_game_state_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output rx_state_e  state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta_q, rx_s_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    // Next-state logic; pulses default low, data holds.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;     // glitch, not a real start bit
                    end else begin
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a break is not
                // mistaken for a stream of start bits.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign state     = state_q;

endmodule

// File: rtl/uart_rx_game_state.sv
// Game-state UART receiver: byte receiver plus START/STOP command decode.
module uart_rx_game_state
    import uart_rx_game_state_pkg::*;
#(
    parameter int         CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter logic [7:0] START_CODE   = GAME_START,
    parameter logic [7:0] STOP_CODE    = GAME_STOP
) (
    input  logic                        uart_clk,
    input  logic                        rst_n,
    input  logic                        uart_rx,
    uart_rx_game_state_if.master        bus
);

    logic [7:0] core_data;
    logic       core_valid;
    logic       core_ferr;
    rx_state_e  core_state;

    logic game_running_q, game_running_d;
    logic state_changed_q, state_changed_d;

    uart_rx_game_state_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk       (uart_clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .rx_data   (core_data),
        .rx_valid  (core_valid),
        .frame_err (core_ferr),
        .state     (core_state)
    );

    // Command decode; only good bytes reach here, so frame errors never act.
    always_comb begin
        game_running_d  = game_running_q;
        state_changed_d = 1'b0;
        if (core_valid) begin
            if (core_data == START_CODE) begin
                game_running_d = 1'b1;
            end else if (core_data == STOP_CODE) begin
                game_running_d = 1'b0;
            end
            state_changed_d = (game_running_d != game_running_q);
        end
    end

    // Game-state registers.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            game_running_q  <= 1'b0;
            state_changed_q <= 1'b0;
        end else begin
            game_running_q  <= game_running_d;
            state_changed_q <= state_changed_d;
        end
    end

    assign bus.rx_data       = core_data;
    assign bus.rx_valid      = core_valid;
    assign bus.frame_err     = core_ferr;
    assign bus.game_running  = game_running_q;
    assign bus.state_changed = state_changed_q;
    assign bus.dbg_state     = core_state;

endmodule

// File: tb/tb_uart_rx_game_state.sv
// Bench for uart_rx_game_state with 16 clocks per bit.
module tb_uart_rx_game_state;
    import uart_rx_game_state_pkg::*;

    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    logic uart_rx;

    int total = 0;
    int bad   = 0;

    // Scoreboard queues: byte events {kind, data} and game_running values
    // expected on each state_changed pulse.
    localparam logic [1:0] K_VALID = 2'b01;
    localparam logic [1:0] K_FERR  = 2'b10;
    logic [9:0] exp_q[$];
    logic [0:0] exp_sc_q[$];

    uart_rx_game_state_if bus ();

    uart_rx_game_state #(
        .CLKS_PER_BIT (CPB),
        .START_CODE   (8'h01),
        .STOP_CODE    (8'h00)
    ) dut (
        .uart_clk (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .bus      (bus)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, elapsed=%0t limit=1000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks; all start and end on a falling clock edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input int stop_low_bits);
        uart_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            idle(CPB);
        end
        if (stop_low_bits > 0) begin
            uart_rx = 1'b0;
            idle(CPB * stop_low_bits);
        end
        uart_rx = 1'b1;
        idle(CPB);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_q.push_back({K_VALID, d});
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    logic last_pulse = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rx_valid || bus.frame_err) begin
                check("pulse_not_consecutive", 32'(last_pulse), 32'd0);
                check("valid_ferr_exclusive", 32'(bus.rx_valid & bus.frame_err), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {22'd0, bus.frame_err, bus.rx_valid, bus.rx_data}, 32'h3FF);
                end else if (bus.rx_valid) begin
                    check("rx_event", {22'd0, K_VALID, bus.rx_data}, 32'(exp_q.pop_front()));
                end else begin
                    check("ferr_event", {22'd0, K_FERR, 8'h00}, 32'(exp_q.pop_front()));
                end
            end
            if (bus.state_changed) begin
                if (exp_sc_q.size() == 0) begin
                    check("unexpected_state_changed", 32'(bus.game_running), 32'hFFFF_FFFF);
                end else begin
                    check("state_changed_value", 32'(bus.game_running), 32'(exp_sc_q.pop_front()));
                end
            end
            last_pulse <= bus.rx_valid | bus.frame_err;
        end else begin
            last_pulse <= 1'b0;
        end
    end

    // Stimulus.
    initial begin
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        idle(5);
        rst_n = 1'b1;
        idle(3);

        // T1: reset values, then a non-command byte.
        check("rst_rx_data", 32'(bus.rx_data), 32'h00);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_game_running", 32'(bus.game_running), 32'd0);
        check("rst_state_changed", 32'(bus.state_changed), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        expect_byte(8'hA5);
        send_byte(8'hA5, 0);
        idle(8);
        check("t1_rx_data_hold", 32'(bus.rx_data), 32'hA5);
        check("t1_game_running", 32'(bus.game_running), 32'd0);

        // T2: START, repeated START, STOP.
        expect_byte(8'h01);
        exp_sc_q.push_back(1'b1);
        send_byte(8'h01, 0);
        idle(8);
        check("t2_running_after_start", 32'(bus.game_running), 32'd1);
        expect_byte(8'h01);
        send_byte(8'h01, 0);
        idle(8);
        check("t2_running_after_repeat", 32'(bus.game_running), 32'd1);
        expect_byte(8'h00);
        exp_sc_q.push_back(1'b0);
        send_byte(8'h00, 0);
        idle(8);
        check("t2_running_after_stop", 32'(bus.game_running), 32'd0);

        // T3: framing error with a 3-bit low stop, then a clean byte.
        exp_q.push_back({K_FERR, 8'h00});
        send_byte(8'h01, 3);
        idle(8);
        check("t3_running_after_ferr", 32'(bus.game_running), 32'd0);
        check("t3_rx_data_unchanged", 32'(bus.rx_data), 32'h00);
        expect_byte(8'h3C);
        send_byte(8'h3C, 0);
        idle(8);
        check("t3_rx_data", 32'(bus.rx_data), 32'h3C);

        // T4: short low glitch on an idle line.
        uart_rx = 1'b0;
        idle(5);
        uart_rx = 1'b1;
        idle(24);
        check("t4_state_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("t4_rx_data_unchanged", 32'(bus.rx_data), 32'h3C);

        // T5: back-to-back frames; first get the game running.
        expect_byte(8'h01);
        exp_sc_q.push_back(1'b1);
        send_byte(8'h01, 0);
        idle(8);
        check("t5_running_pre", 32'(bus.game_running), 32'd1);
        expect_byte(8'h55);
        expect_byte(8'hFF);
        expect_byte(8'h00);
        exp_sc_q.push_back(1'b0);
        send_byte(8'h55, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h00, 0);
        idle(8);
        check("t5_rx_data", 32'(bus.rx_data), 32'h00);
        check("t5_running_cleared", 32'(bus.game_running), 32'd0);

        // T6: asynchronous reset in the middle of a frame.
        expect_byte(8'h01);
        exp_sc_q.push_back(1'b1);
        send_byte(8'h01, 0);
        idle(16);
        check("t6_running_pre", 32'(bus.game_running), 32'd1);
        uart_rx = 1'b0;
        idle(CPB);
        uart_rx = 1'b1;
        idle(CPB);
        uart_rx = 1'b0;
        idle(20);
        check("t6_state_data", 32'(bus.dbg_state), 32'(ST_DATA));
        #3;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        #1;
        check("t6_rst_rx_data", 32'(bus.rx_data), 32'h00);
        check("t6_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("t6_rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("t6_rst_game_running", 32'(bus.game_running), 32'd0);
        check("t6_rst_state_changed", 32'(bus.state_changed), 32'd0);
        check("t6_rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        idle(4);
        rst_n = 1'b1;
        idle(CPB);
        expect_byte(8'h01);
        exp_sc_q.push_back(1'b1);
        send_byte(8'h01, 0);
        idle(8);
        check("t6_running_after", 32'(bus.game_running), 32'd1);

        // Drain and report.
        idle(40);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("exp_sc_q_drained", exp_sc_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
